// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: PC handshake, instruction-memory read port and decode-side
// instruction buffer head. The fetch unit is the master; the surrounding
// pipeline (PC, memory, decoder) is the slave.
interface fetch_unit_if;
    // PC side
    logic [31:0] pcAddress;
    logic        pcAdvance;
    logic        flush;
    // Instruction memory side
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memData;
    // Decode side
    logic        instrValid;
    logic [31:0] instruction;
    logic [31:0] instrPC;
    logic        instrReady;
    logic        bufferFull;

    modport master (
        input  pcAddress, flush, memAck, memData, instrReady,
        output pcAdvance, memReq, memAddr, instrValid, instruction, instrPC, bufferFull
    );

    modport slave (
        output pcAddress, flush, memAck, memData, instrReady,
        input  pcAdvance, memReq, memAddr, instrValid, instruction, instrPC, bufferFull
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues one read at a time to instruction memory,
// buffers returned words with their fetch address in a small circular FIFO,
// pulses pcAdvance when a word is accepted, and drops buffered or in-flight
// words when the pipeline is flushed. A request that is flushed before its
// acknowledge is still held until memory completes it (DISCARD), because the
// memory protocol does not allow a request to be withdrawn.
module fetch_unit #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clock,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t            stateReg, stateNext;
    logic              memReqReg, memReqNext;
    logic [31:0]       memAddrReg, memAddrNext;

    logic [PTR_W-1:0]  rdPtrReg, rdPtrNext;
    logic [PTR_W-1:0]  wrPtrReg, wrPtrNext;
    logic [CNT_W-1:0]  countReg, countNext;

    logic              enqueue;
    logic              dequeue;
    logic              headValid;
    logic              advance;

    logic [31:0]       wordArr [FIFO_DEPTH];
    logic [31:0]       addrArr [FIFO_DEPTH];

    // A word is accepted only when a live (not flushed) request completes;
    // that same event tells the PC to step.
    assign advance   = memReqReg && bus.memAck && !bus.flush && (stateReg == REQ);
    assign enqueue   = advance;
    assign headValid = (countReg != '0);
    assign dequeue   = headValid && bus.instrReady;

    // Fetch sequencer state and held request registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            stateReg   <= IDLE;
            memReqReg  <= 1'b0;
            memAddrReg <= '0;
        end else begin
            stateReg   <= stateNext;
            memReqReg  <= memReqNext;
            memAddrReg <= memAddrNext;
        end
    end

    // Next-state logic: issue when there is room, hold the request until acknowledge
    always_comb begin
        stateNext   = stateReg;
        memReqNext  = memReqReg;
        memAddrNext = memAddrReg;
        case (stateReg)
            IDLE: begin
                // Room is judged on the current count; a same-cycle dequeue
                // only opens the slot for sampling on the following cycle.
                if (!bus.flush && (countReg < DEPTH_CNT)) begin
                    memAddrNext = bus.pcAddress;
                    memReqNext  = 1'b1;
                    stateNext   = REQ;
                end
            end
            REQ: begin
                if (bus.memAck) begin
                    memReqNext = 1'b0;
                    stateNext  = IDLE;
                end else if (bus.flush) begin
                    stateNext = DISCARD;
                end
            end
            DISCARD: begin
                // Further flushes change nothing here: the word is dropped anyway.
                if (bus.memAck) begin
                    memReqNext = 1'b0;
                    stateNext  = IDLE;
                end
            end
            default: begin
                stateNext  = IDLE;
                memReqNext = 1'b0;
            end
        endcase
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            rdPtrReg <= '0;
            wrPtrReg <= '0;
            countReg <= '0;
        end else begin
            rdPtrReg <= rdPtrNext;
            wrPtrReg <= wrPtrNext;
            countReg <= countNext;
        end
    end

    // FIFO bookkeeping: flush empties the buffer and wins over enqueue/dequeue
    always_comb begin
        rdPtrNext = rdPtrReg;
        wrPtrNext = wrPtrReg;
        countNext = countReg;
        if (bus.flush) begin
            rdPtrNext = '0;
            wrPtrNext = '0;
            countNext = '0;
        end else begin
            if (enqueue) begin
                wrPtrNext = wrPtrReg + PTR_W'(1);
            end
            if (dequeue) begin
                rdPtrNext = rdPtrReg + PTR_W'(1);
            end
            case ({enqueue, dequeue})
                2'b10:   countNext = countReg + CNT_W'(1);
                2'b01:   countNext = countReg - CNT_W'(1);
                default: countNext = countReg;
            endcase
        end
    end

    // Buffer storage: one word/address pair per slot
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : gEntry
            logic [31:0] wordReg;
            logic [31:0] addrReg;

            // Capture the returned word and its fetch address when this slot is the write target
            always_ff @(posedge clock) begin
                if (!reset) begin
                    wordReg <= '0;
                    addrReg <= '0;
                end else if (enqueue && (wrPtrReg == PTR_W'(gi))) begin
                    wordReg <= bus.memData;
                    addrReg <= memAddrReg;
                end
            end

            assign wordArr[gi] = wordReg;
            assign addrArr[gi] = addrReg;
        end
    endgenerate

    // Outputs. The head is forced to zero when empty so stale slot contents
    // never reach decode.
    assign bus.memReq      = memReqReg;
    assign bus.memAddr     = memAddrReg;
    assign bus.pcAdvance   = advance;
    assign bus.instrValid  = headValid;
    assign bus.instruction = headValid ? wordArr[rdPtrReg] : '0;
    assign bus.instrPC     = headValid ? addrArr[rdPtrReg] : '0;
    assign bus.bufferFull  = (countReg == DEPTH_CNT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a PC model, a configurable memory responder
// and a queue of expected {pc, word} entries pushed on accepted fetches and
// popped when decode takes the head.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] PC_START = 32'h0000_18C0;

    logic clock = 1'b0;
    logic reset;

    fetch_unit_if bus();

    fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    entry_t      expQ[$];
    logic [31:0] poppedPc[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] pcModel, reqAddrModel, flushTarget;
    logic        expReq, reqKilled;
    int          reqAge, waitStates, flushAtAge;
    int          cycleNum, lastPopCycle, popCount, advCount;
    bit          readyKnob, flushOnAck, gapCheck;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic initModel();
        pcModel      = PC_START;
        reqAddrModel = '0;
        flushTarget  = 32'h0000_4000;
        expReq       = 1'b0;
        reqKilled    = 1'b0;
        reqAge       = 0;
        waitStates   = 0;
        flushAtAge   = -1;
        cycleNum     = 0;
        lastPopCycle = -1;
        popCount     = 0;
        advCount     = 0;
        readyKnob    = 1'b1;
        flushOnAck   = 1'b0;
        gapCheck     = 1'b0;
        expQ.delete();
        poppedPc.delete();
    endtask

    // Hold reset low with memAck and flush high; every output must read zero.
    task automatic resetDut(input int n);
        reset           = 1'b0;
        bus.memAck      = 1'b1;
        bus.flush       = 1'b1;
        bus.memData     = 32'hFFFF_FFFF;
        bus.instrReady  = 1'b1;
        bus.pcAddress   = 32'h1234_5678;
        repeat (n) begin
            @(posedge clock); #1;
            expectEq("rstMemReq",      32'(bus.memReq),     32'd0);
            expectEq("rstMemAddr",     bus.memAddr,         32'd0);
            expectEq("rstInstrValid",  32'(bus.instrValid), 32'd0);
            expectEq("rstInstruction", bus.instruction,     32'd0);
            expectEq("rstInstrPC",     bus.instrPC,         32'd0);
            expectEq("rstBufferFull",  32'(bus.bufferFull), 32'd0);
            expectEq("rstPcAdvance",   32'(bus.pcAdvance),  32'd0);
        end
        reset      = 1'b1;
        bus.memAck = 1'b0;
        bus.flush  = 1'b0;
        initModel();
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic doCycle();
        logic   ackNow, flushNow, expAdv, nextReq;
        int     sizeBefore;
        entry_t e;

        ackNow   = bus.memReq && (reqAge >= waitStates);
        flushNow = (flushOnAck && ackNow) ||
                   ((flushAtAge >= 0) && bus.memReq && !ackNow && (reqAge == flushAtAge));
        if (flushNow && !ackNow) flushAtAge = -1;

        bus.pcAddress  = pcModel;
        bus.instrReady = readyKnob;
        bus.memAck     = ackNow;
        bus.memData    = reqKilled ? 32'hDEAD_BEEF : memWord(bus.memAddr);
        bus.flush      = flushNow;
        #1;

        sizeBefore = expQ.size();
        expAdv     = expReq && ackNow && !flushNow && !reqKilled;

        expectEq("pcAdvance",  32'(bus.pcAdvance),  32'(expAdv));
        expectEq("memReq",     32'(bus.memReq),     32'(expReq));
        if (expReq) expectEq("memAddr", bus.memAddr, reqAddrModel);
        expectEq("instrValid", 32'(bus.instrValid), 32'(sizeBefore != 0));
        expectEq("bufferFull", 32'(bus.bufferFull), 32'(sizeBefore == DEPTH));
        if (bus.pcAdvance) advCount++;

        if (!flushNow && readyKnob && (sizeBefore != 0)) begin
            e = expQ.pop_front();
            expectEq("instrPC",     bus.instrPC,     e.pc);
            expectEq("instruction", bus.instruction, e.word);
            $display("deq cycle %0d pc=%h instr=%h", cycleNum, bus.instrPC, bus.instruction);
            poppedPc.push_back(bus.instrPC);
            popCount++;
            if (gapCheck && (lastPopCycle >= 0))
                expectEq("issueGap", 32'(cycleNum - lastPopCycle), 32'd2);
            lastPopCycle = cycleNum;
        end
        if (expAdv) expQ.push_back('{reqAddrModel, memWord(reqAddrModel)});
        if (flushNow) expQ.delete();

        if (expReq) nextReq = !ackNow;
        else        nextReq = !flushNow && (sizeBefore < DEPTH);
        if (!expReq && nextReq) reqAddrModel = pcModel;
        if (expReq && ackNow)        reqKilled = 1'b0;
        else if (expReq && flushNow) reqKilled = 1'b1;
        if (expReq && !ackNow) reqAge++;
        else                   reqAge = 0;
        if (expAdv)   pcModel = pcModel + 32'd4;
        if (flushNow) pcModel = flushTarget;
        expReq = nextReq;
        cycleNum++;

        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        initModel();

        // Reset with memAck and flush asserted
        resetDut(3);

        // Zero-wait stream: one instruction every two cycles
        gapCheck = 1'b1;
        repeat (20) doCycle();
        expectEq("streamPops", 32'(popCount), 32'd9);
        expectEq("streamPc0", (poppedPc.size() > 0) ? poppedPc[0] : 32'd0, 32'h0000_18C0);
        expectEq("streamPc1", (poppedPc.size() > 1) ? poppedPc[1] : 32'd0, 32'h0000_18C4);
        expectEq("streamPc2", (poppedPc.size() > 2) ? poppedPc[2] : 32'd0, 32'h0000_18C8);

        // Three wait states
        resetDut(2);
        waitStates = 3;
        repeat (6) doCycle();
        expectEq("waitAdvPulses", 32'(advCount),     32'd1);
        expectEq("waitPops",      32'(popCount),     32'd1);
        expectEq("waitPopCycle",  32'(lastPopCycle), 32'd5);

        // Backpressure fills the buffer, one dequeue lets one more fetch in
        resetDut(2);
        readyKnob = 1'b0;
        for (int i = 0; i < 20 && !bus.bufferFull; i++) doCycle();
        expectEq("bpFull", 32'(bus.bufferFull), 32'd1);
        repeat (4) doCycle();
        expectEq("bpNoReq", 32'(bus.memReq), 32'd0);
        readyKnob = 1'b1;
        doCycle();
        readyKnob = 1'b0;
        repeat (4) doCycle();
        readyKnob = 1'b1;
        repeat (6) doCycle();
        expectEq("bpPc0", (poppedPc.size() > 0) ? poppedPc[0] : 32'd0, 32'h0000_18C0);
        expectEq("bpPc1", (poppedPc.size() > 1) ? poppedPc[1] : 32'd0, 32'h0000_18C4);
        expectEq("bpPc2", (poppedPc.size() > 2) ? poppedPc[2] : 32'd0, 32'h0000_18C8);

        // Flush with a request outstanding; the late word is dropped
        resetDut(2);
        waitStates  = 3;
        flushAtAge  = 1;
        flushTarget = 32'h0000_4000;
        repeat (12) doCycle();
        expectEq("redirectPops", 32'(popCount), 32'd1);
        expectEq("redirectPc", (poppedPc.size() > 0) ? poppedPc[0] : 32'd0, 32'h0000_4000);

        // Flush coincident with memAck while one entry is buffered
        resetDut(2);
        readyKnob   = 1'b0;
        flushTarget = 32'h0000_5000;
        for (int i = 0; i < 10 && !bus.instrValid; i++) doCycle();
        expectEq("oneBuffered", 32'(bus.instrValid), 32'd1);
        doCycle();
        flushOnAck = 1'b1;
        readyKnob  = 1'b1;
        doCycle();
        flushOnAck = 1'b0;
        expectEq("flushAckValid", 32'(bus.instrValid), 32'd0);
        expectEq("flushAckFull",  32'(bus.bufferFull), 32'd0);
        repeat (4) doCycle();
        expectEq("flushAckRedirect", (poppedPc.size() > 0) ? poppedPc[0] : 32'd0, 32'h0000_5000);

        // Reset in the middle of a request
        waitStates = 3;
        for (int i = 0; i < 10 && !bus.memReq; i++) doCycle();
        expectEq("midReqUp", 32'(bus.memReq), 32'd1);
        reset      = 1'b0;
        bus.memAck = 1'b0;
        bus.flush  = 1'b0;
        @(posedge clock); #1;
        expectEq("midReqRstReq",   32'(bus.memReq),     32'd0);
        expectEq("midReqRstAddr",  bus.memAddr,         32'd0);
        expectEq("midReqRstValid", 32'(bus.instrValid), 32'd0);
        reset = 1'b1;
        initModel();
        repeat (6) doCycle();
        expectEq("recoverPc", (poppedPc.size() > 0) ? poppedPc[0] : 32'd0, PC_START);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
